// File: rtl/gt_int_bitserial_pkg.sv
// Purpose: shared FSM state encoding for the bit-serial signed compare block.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package gt_int_bitserial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/gt_serial_cell.sv
// Purpose: one-bit greater-than / equality step, optional bit inversion for the sign bit.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module gt_serial_cell (
  input  logic a,
  input  logic b,
  input  logic gt_in,
  input  logic eq_in,
  input  logic inv,
  output logic gt_out,
  output logic eq_out
);

  logic a_x;
  logic b_x;

  // Flipping both sign bits turns the unsigned borrow chain into a signed compare;
  // equality is unaffected because both bits flip together.
  assign a_x    = a ^ inv;
  assign b_x    = b ^ inv;
  assign gt_out = (a_x & ~b_x) | (~(a_x ^ b_x) & gt_in);
  assign eq_out = eq_in & ~(a_x ^ b_x);

endmodule

// File: rtl/gt_int_bitserial.sv
// Purpose: bit-serial signed A > B and A == B, one bit per clock LSB first.
// Latency: accept at edge t0, out_valid visible after edge t0+WIDTH; one op per WIDTH+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, indefinitely.
module gt_int_bitserial
  import gt_int_bitserial_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             Y,
  output logic             Y_eq
);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   sa;
  logic [WIDTH-1:0]   sb;
  logic               gt;
  logic               eq;
  logic               gt_nxt;
  logic               eq_nxt;
  logic               last_bit;

  // The final step handles the sign bit, which the cell inverts.
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  gt_serial_cell u_cell (
    .a      (sa[0]),
    .b      (sb[0]),
    .gt_in  (gt),
    .eq_in  (eq),
    .inv    (last_bit),
    .gt_out (gt_nxt),
    .eq_out (eq_nxt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; results are gated so Y/Y_eq read 0 outside DONE.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (last_bit) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign Y    = out_valid & gt;
  assign Y_eq = out_valid & eq;

  // Datapath: load operands on accept, then consume one bit pair per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      gt  <= 1'b0;
      eq  <= 1'b1;
      sa  <= '0;
      sb  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            sa  <= A;
            sb  <= B;
            cnt <= '0;
            gt  <= 1'b0;
            eq  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          gt  <= gt_nxt;
          eq  <= eq_nxt;
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          cnt <= cnt + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gt_int_bitserial.sv
// Purpose: self-checking bench for gt_int_bitserial at WIDTH=16 and WIDTH=1.
// Latency: expects out_valid exactly WIDTH edges after the accept edge.
// Backpressure: exercises out_ready stalls and ignored in_valid pulses.
module tb_gt_int_bitserial;

  logic clk = 1'b0;
  logic rst;

  logic        iv16, ir16, ov16, or16, y16, yeq16;
  logic [15:0] a16, b16;
  logic        iv1, ir1, ov1, or1, y1, yeq1;
  logic [0:0]  a1, b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gt_int_bitserial #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(iv16), .in_ready(ir16), .A(a16), .B(b16),
    .out_valid(ov16), .out_ready(or16), .Y(y16), .Y_eq(yeq16)
  );

  gt_int_bitserial #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1),
    .out_valid(ov1), .out_ready(or1), .Y(y1), .Y_eq(yeq1)
  );

  // Reference: plain signed arithmetic on the operand values.
  function automatic logic ref_gt16(input logic [15:0] a, input logic [15:0] b);
    return $signed(a) > $signed(b);
  endfunction

  function automatic logic ref_gt1(input logic [0:0] a, input logic [0:0] b);
    return $signed(a) > $signed(b);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full WIDTH=16 operation; hold = cycles out_ready stays low in DONE.
  task automatic op16(input logic [15:0] a, input logic [15:0] b, input int hold, input string nm);
    int   lat;
    logic exp_gt, exp_eq;
    exp_gt = ref_gt16(a, b);
    exp_eq = (a == b);
    checks++;
    if (ir16 !== 1'b1) begin errors++; $display("FAIL %s in_ready before accept got %b want 1", nm, ir16); end
    a16 = a; b16 = b; iv16 = 1'b1; or16 = (hold == 0);
    tick();
    iv16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom);
    lat = 0;
    while (ov16 !== 1'b1 && lat < 40) begin
      checks++;
      if (ir16 !== 1'b0) begin errors++; $display("FAIL %s in_ready busy got %b want 0", nm, ir16); end
      tick();
      lat++;
    end
    checks++;
    if (lat !== 16) begin errors++; $display("FAIL %s latency got %0d want 16", nm, lat); end
    checks++;
    if (y16 !== exp_gt) begin errors++; $display("FAIL %s Y got %b want %b (A=%h B=%h)", nm, y16, exp_gt, a, b); end
    checks++;
    if (yeq16 !== exp_eq) begin errors++; $display("FAIL %s Y_eq got %b want %b (A=%h B=%h)", nm, yeq16, exp_eq, a, b); end
    for (int i = 0; i < hold; i++) begin
      iv16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom);
      tick();
      checks++;
      if (ov16 !== 1'b1 || y16 !== exp_gt || yeq16 !== exp_eq || ir16 !== 1'b0) begin
        errors++;
        $display("FAIL %s hold%0d ov=%b Y=%b Y_eq=%b ir=%b want 1 %b %b 0", nm, i, ov16, y16, yeq16, ir16, exp_gt, exp_eq);
      end
    end
    iv16 = 1'b0;
    or16 = 1'b1;
    tick();
    checks++;
    if (ov16 !== 1'b0 || ir16 !== 1'b1) begin
      errors++; $display("FAIL %s after handshake ov=%b ir=%b want 0 1", nm, ov16, ir16);
    end
  endtask

  task automatic op1(input logic [0:0] a, input logic [0:0] b, input string nm);
    int   lat;
    logic exp_gt, exp_eq;
    exp_gt = ref_gt1(a, b);
    exp_eq = (a == b);
    a1 = a; b1 = b; iv1 = 1'b1; or1 = 1'b1;
    tick();
    iv1 = 1'b0; a1 = ~a; b1 = ~b;
    lat = 0;
    while (ov1 !== 1'b1 && lat < 10) begin tick(); lat++; end
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL %s latency got %0d want 1", nm, lat); end
    checks++;
    if (y1 !== exp_gt || yeq1 !== exp_eq) begin
      errors++; $display("FAIL %s Y=%b Y_eq=%b want %b %b (A=%b B=%b)", nm, y1, yeq1, exp_gt, exp_eq, a, b);
    end
    tick();
    checks++;
    if (ov1 !== 1'b0 || ir1 !== 1'b1) begin
      errors++; $display("FAIL %s after handshake ov=%b ir=%b want 0 1", nm, ov1, ir1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (ir16 !== 1'b1 || ov16 !== 1'b0 || y16 !== 1'b0 || yeq16 !== 1'b0) begin
      errors++; $display("FAIL reset16 ir=%b ov=%b Y=%b Y_eq=%b want 1 0 0 0", ir16, ov16, y16, yeq16);
    end
    checks++;
    if (ir1 !== 1'b1 || ov1 !== 1'b0 || y1 !== 1'b0 || yeq1 !== 1'b0) begin
      errors++; $display("FAIL reset1 ir=%b ov=%b Y=%b Y_eq=%b want 1 0 0 0", ir1, ov1, y1, yeq1);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    op16(16'h0005, 16'h0003, 0, "d_5_3");
    op16(16'hFFFF, 16'h0000, 0, "d_m1_0");
    op16(16'h0000, 16'hFFFF, 0, "d_0_m1");
    op16(16'h7FFF, 16'h8000, 0, "d_max_min");
    op16(16'h8000, 16'h7FFF, 0, "d_min_max");
    op16(16'h1234, 16'h1234, 0, "d_eq");
    op16(16'h8000, 16'h8000, 0, "d_eq_min");
  endtask

  task automatic test_hold();
    op16(16'hFFFE, 16'hFFFD, 5, "hold_gt");
    op16(16'h0042, 16'h0042, 5, "hold_eq");
    op16(16'h0001, 16'h0002, 0, "after_hold");
  endtask

  task automatic test_rst_mid();
    int seen;
    a16 = 16'h0005; b16 = 16'h0003; iv16 = 1'b1; or16 = 1'b1;
    tick();
    iv16 = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (ir16 !== 1'b1 || ov16 !== 1'b0) begin
      errors++; $display("FAIL rst_mid ir=%b ov=%b want 1 0", ir16, ov16);
    end
    seen = 0;
    repeat (20) begin tick(); if (ov16 === 1'b1) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rst_mid stray out_valid cycles got %0d want 0", seen); end
  endtask

  task automatic test_width1();
    op1(1'b0, 1'b1, "w1_0_1");
    op1(1'b1, 1'b0, "w1_1_0");
    op1(1'b1, 1'b1, "w1_1_1");
    op1(1'b0, 1'b0, "w1_0_0");
  endtask

  task automatic test_back_to_back();
    logic [15:0] ra, rb;
    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
      op16(ra, rb, 0, "rand16");
    end
    for (int i = 0; i < 20; i++) begin
      op1(1'($urandom), 1'($urandom), "rand1");
    end
  endtask

  initial begin
    rst = 1'b1;
    iv16 = 1'b0; or16 = 1'b1; a16 = '0; b16 = '0;
    iv1 = 1'b0; or1 = 1'b1; a1 = '0; b1 = '0;
    test_reset();
    test_directed();
    test_hold();
    test_rst_mid();
    test_width1();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
